// File: rtl/bit32_1to3_demux_reg_if.sv
// Handshake bundle for the registered 1-to-3 demux: one producer stream in,
// three consumer streams out, plus the drop-error side band.
interface bit32_1to3_demux_reg_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic [WIDTH-1:0] in_data;

  logic             out1_valid, out2_valid, out3_valid;
  logic             out1_ready, out2_ready, out3_ready;
  logic [WIDTH-1:0] out1_data, out2_data, out3_data;

  logic             drop_err;
  logic [CNT_W-1:0] drop_count;
  logic             err_clr;

  // Environment side: producer, consumers and error-clear source.
  modport master (
    output in_valid, in_sel, in_data, out1_ready, out2_ready, out3_ready, err_clr,
    input  in_ready, out1_valid, out2_valid, out3_valid,
    input  out1_data, out2_data, out3_data, drop_err, drop_count
  );

  modport slave (
    input  in_valid, in_sel, in_data, out1_ready, out2_ready, out3_ready, err_clr,
    output in_ready, out1_valid, out2_valid, out3_valid,
    output out1_data, out2_data, out3_data, drop_err, drop_count
  );
endinterface

// File: rtl/bit32_1to3_demux_reg.sv
// Registered 1-to-3 demultiplexer with valid/ready handshaking. Each output port
// holds one entry; words with select 2'b11 are dropped and counted.
module bit32_1to3_demux_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  bit32_1to3_demux_reg_if.slave  bus
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [2:0]       out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q [3];
  logic [WIDTH-1:0] out_data_d [3];
  logic             drop_err_q, drop_err_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;

  logic [2:0] out_ready;
  logic [2:0] sel_oh;
  logic       is_drop;
  logic       in_ready;
  logic       accept;

  always_comb begin
    out_ready = {bus.out3_ready, bus.out2_ready, bus.out1_ready};
    sel_oh    = 3'b000;
    unique case (bus.in_sel)
      2'b00:   sel_oh = 3'b001;
      2'b01:   sel_oh = 3'b010;
      2'b10:   sel_oh = 3'b100;
      default: sel_oh = 3'b000;
    endcase
    is_drop  = (bus.in_sel == 2'b11);
    // A full port can still accept if it is draining in the same cycle.
    in_ready = is_drop | (|(sel_oh & (~out_valid_q | out_ready)));
    accept   = bus.in_valid & in_ready;

    for (int i = 0; i < 3; i++) begin
      out_valid_d[i] = out_valid_q[i] & ~out_ready[i];
      out_data_d[i]  = out_data_q[i];
      if (accept && sel_oh[i]) begin
        out_valid_d[i] = 1'b1;
        out_data_d[i]  = bus.in_data;
      end
    end

    drop_err_d   = drop_err_q;
    drop_count_d = drop_count_q;
    if (bus.err_clr) begin
      drop_err_d   = 1'b0;
      drop_count_d = '0;
    end
    // Applied after the clear so a simultaneous drop wins.
    if (accept && is_drop) begin
      drop_err_d = 1'b1;
      if (drop_count_d != CntMax) drop_count_d = drop_count_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= '0;
      drop_err_q   <= 1'b0;
      drop_count_q <= '0;
      for (int i = 0; i < 3; i++) out_data_q[i] <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      drop_err_q   <= drop_err_d;
      drop_count_q <= drop_count_d;
      for (int i = 0; i < 3; i++) out_data_q[i] <= out_data_d[i];
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out1_valid = out_valid_q[0];
  assign bus.out2_valid = out_valid_q[1];
  assign bus.out3_valid = out_valid_q[2];
  assign bus.out1_data  = out_data_q[0];
  assign bus.out2_data  = out_data_q[1];
  assign bus.out3_data  = out_data_q[2];
  assign bus.drop_err   = drop_err_q;
  assign bus.drop_count = drop_count_q;

endmodule

// File: doc/bit32_1to3_demux_reg.md
# bit32_1to3_demux_reg

Registered 32-bit 1-to-3 demultiplexer with valid/ready handshaking. It is the distribution counterpart of the 32-bit 3-to-1 select path: one producer stream is steered to one of three consumer ports by a 2-bit select, using the same select encoding as the 3-input mux. Each output port holds one registered entry. Invalid selects are dropped and counted. It sits between a single result source and three destination units, e.g. write-back targets.

## Interface
Parameters:
- WIDTH, 32, data width of every port
- CNT_W, 8, width of the drop counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  producer has a word
- in_ready  output  1  word will be accepted this cycle
- in_sel  input  2  destination: 2'b00→port 1, 2'b01→port 2, 2'b10→port 3, 2'b11→invalid
- in_data  input  WIDTH  word to distribute
- out1_valid, out2_valid, out3_valid  output  1 each  port holds a word
- out1_ready, out2_ready, out3_ready  input  1 each  consumer takes the word this cycle
- out1_data, out2_data, out3_data  output  WIDTH each  registered port data
- drop_err  output  1  sticky flag, set by any accepted invalid-select word
- drop_count  output  CNT_W  count of dropped words, saturating
- err_clr  input  1  clears drop_err and drop_count

One clock, clk. reset is synchronous and active-high.

## Operation
- Port N has one entry register (outN_data, outN_valid). It is empty when outN_valid=0.
- in_ready is combinational:
  - sel 00/01/10: in_ready = ~outN_valid | outN_ready for the selected port.
  - sel 11: in_ready = 1.
  - in_ready does not depend on in_valid.
- Accept means in_valid & in_ready at a rising edge. On accept with a valid select:
  - outN_data <= in_data.
  - outN_valid <= 1.
- Drain means outN_valid & outN_ready at an edge. On drain with no accept to the same port, outN_valid <= 0.
- Drain and accept on the same port in the same cycle: the new word replaces the old one and outN_valid stays 1. This allows one word per cycle per port.
- Unselected ports are unaffected by in_data and in_sel. Their data holds while valid.
- outN_data changes only on an accept to port N. Otherwise it holds, including after a drain.
- Accept with sel 11:
  - No port changes.
  - drop_err <= 1.
  - drop_count increments and saturates at 2^CNT_W−1 (255 by default).
- err_clr sets drop_err <= 0 and drop_count <= 0.
- err_clr in the same cycle as a drop: the drop wins. Result is drop_err=1 and drop_count=1.
- The producer must hold in_sel and in_data stable while in_valid=1 and in_ready=0. Behaviour is undefined if it does not.

## Timing
- Reset values: all outN_valid=0, all outN_data=0, drop_err=0, drop_count=0. in_ready follows from these (1 for every select after reset).
- Reset mid-operation discards pending entries. Reset has priority over accept, drain and err_clr in the same cycle.
- Latency: a word accepted at edge k appears with outN_valid=1 after edge k (visible in cycle k+1).
- Throughput: one word per cycle total. A port with its ready held high sustains one word per cycle.
- Full port N with outN_ready=0 and in_sel=N gives in_ready=0. The producer stalls, and the other ports keep draining.
- Back-to-back words to different ports need no bubble.
- drop_err and drop_count update at the accept edge.

## Test plan
- Reset, then in_valid=1, sel=00, data=32'h1AAA, out1_ready=0 → next cycle out1_valid=1 and out1_data=32'h1AAA, while out2_valid and out3_valid stay 0. A second word 32'h3A4C to port 1 → in_ready=0, and out1_data holds 32'h1AAA. Raise out1_ready → that cycle accepts, and out1_data becomes 32'h3A4C.
- Streaming: all readies high, sel sequence 00,10,01 with data 32'h1AAA, 32'h4BCA, 32'h3A4C, one per cycle → each word appears on the correct port one cycle after its accept, with no stalls (in_ready=1 throughout).
- Invalid select: three accepts with sel=11 → all ports unchanged, drop_err=1, drop_count=3. Assert err_clr together with a fourth sel=11 accept → drop_count=1 and drop_err=1. err_clr alone → both 0.
- Saturation: 300 sel=11 accepts → drop_count=255.
- Mid-operation reset: fill all three ports with readies low, then assert reset for one cycle during an accept → all valids 0, all data 0, drop counter 0, and the word that was being accepted is not stored.
- Random stimulus with a scoreboard (random valids, readies and selects) → each port's output order equals its input order, with no loss or duplication and no word on an unselected port.
